// File: rtl/apb_slave_mem_if.sv
// APB bus bundle for apb_slave_mem: request fields from the master,
// response fields from the completer. PCLK and PRESET stay plain ports
// on the completer.
interface apb_slave_mem_if;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [6:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB completer with a byte-wide register file of DEPTH
// locations, WAIT_CYCLES wait states per transfer and PSLVERR for
// out-of-range addresses.
// Optional feature macro: APB_SLAVE_WPROT_EN -- when defined, writes to
// locations 0..WPROT_LIMIT-1 are rejected with PSLVERR and leave storage
// untouched; reads of those locations behave normally.
module apb_slave_mem #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 0,
    parameter int WPROT_LIMIT = 8
) (
    input  logic          PCLK,
    input  logic          PRESET,
    apb_slave_mem_if.slave bus
);

    localparam logic [6:0] DEPTH_L = 7'(DEPTH);
    localparam logic [3:0] WAIT_L  = 4'(WAIT_CYCLES);
`ifdef APB_SLAVE_WPROT_EN
    localparam logic [6:0] WPROT_L = 7'(WPROT_LIMIT);
`else
    localparam logic [6:0] unused_wprot_l = 7'(WPROT_LIMIT);
`endif

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        capture;
    logic        complete;

    // Transfer fields latched at the setup edge
    logic        write_q;
    logic [5:0]  addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rdata_q;
    logic        err_q;

    // Storage is always 64 entries wide so the 6-bit address indexes it
    // without truncation; entries at or above DEPTH are never written and
    // stay at their reset value.
    logic [7:0]  mem [64];

    // Bit 6 selects between the two completers upstream and is not decoded here
    logic        unused_addr_msb;
    assign unused_addr_msb = bus.PADDR[6];

    // Error decode for a transfer presented in its setup phase
    function automatic logic calc_err(input logic [5:0] addr, input logic wr);
        logic e;
        e = ({1'b0, addr} >= DEPTH_L);
`ifdef APB_SLAVE_WPROT_EN
        if (wr && ({1'b0, addr} < WPROT_L))
            e = 1'b1;
`else
        if (wr) e = e;
`endif
        return e;
    endfunction

    // State and wait-counter registers
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: setup starts a transfer, PSEL low aborts it,
    // the counter runs only while the master holds PENABLE
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        capture  = 1'b0;
        complete = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.PSEL && !bus.PENABLE) begin
                    state_d = ACCESS;
                    cnt_d   = WAIT_L;
                    capture = 1'b1;
                end
            end
            ACCESS: begin
                if (!bus.PSEL) begin
                    state_d = IDLE;
                end else if (cnt_q != 4'd0) begin
                    if (bus.PENABLE)
                        cnt_d = cnt_q - 4'd1;
                end else if (bus.PENABLE) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Latch the transfer fields, read data and error flag at the setup edge
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (capture) begin
            write_q <= bus.PWRITE;
            addr_q  <= bus.PADDR[5:0];
            wdata_q <= bus.PWDATA;
            rdata_q <= mem[bus.PADDR[5:0]];
            err_q   <= calc_err(bus.PADDR[5:0], bus.PWRITE);
        end
    end

    // Storage: written only on the completion edge of an error-free write
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            for (int i = 0; i < 64; i++)
                mem[i] <= '0;
        end else if (complete && write_q && !err_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

    // Response outputs decoded from registers only
    always_comb begin
        bus.PREADY  = (state_q == ACCESS) && (cnt_q == 4'd0);
        bus.PSLVERR = bus.PREADY && err_q;
        bus.PRDATA  = (bus.PREADY && !write_q && !err_q) ? rdata_q : 8'h00;
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: three completers with different
// DEPTH/WAIT_CYCLES share one bus driver; a table of transfers plus
// hand-written abort, reset and back-to-back sequences.
module tb_apb_slave_mem;

    logic       PCLK;
    logic       PRESET;
    int         sel;
    logic       psel, penable, pwrite;
    logic [6:0] paddr;
    logic [7:0] pwdata;
    logic       m_pready, m_pslverr;
    logic [7:0] m_prdata;

    int checks = 0;
    int errors = 0;

    apb_slave_mem_if if0 ();
    apb_slave_mem_if if1 ();
    apb_slave_mem_if if2 ();

    // if0: DEPTH 64, no waits; if1: DEPTH 32, 2 waits; if2: DEPTH 64, 3 waits
    apb_slave_mem #(.DEPTH(64), .WAIT_CYCLES(0), .WPROT_LIMIT(8)) dut0 (.PCLK(PCLK), .PRESET(PRESET), .bus(if0));
    apb_slave_mem #(.DEPTH(32), .WAIT_CYCLES(2), .WPROT_LIMIT(8)) dut1 (.PCLK(PCLK), .PRESET(PRESET), .bus(if1));
    apb_slave_mem #(.DEPTH(64), .WAIT_CYCLES(3), .WPROT_LIMIT(8)) dut2 (.PCLK(PCLK), .PRESET(PRESET), .bus(if2));

    assign if0.PSEL = psel && (sel == 0);
    assign if1.PSEL = psel && (sel == 1);
    assign if2.PSEL = psel && (sel == 2);
    assign if0.PENABLE = penable;
    assign if1.PENABLE = penable;
    assign if2.PENABLE = penable;
    assign if0.PWRITE = pwrite;
    assign if1.PWRITE = pwrite;
    assign if2.PWRITE = pwrite;
    assign if0.PADDR = paddr;
    assign if1.PADDR = paddr;
    assign if2.PADDR = paddr;
    assign if0.PWDATA = pwdata;
    assign if1.PWDATA = pwdata;
    assign if2.PWDATA = pwdata;

    always_comb begin
        m_pready  = (sel == 0) ? if0.PREADY  : (sel == 1) ? if1.PREADY  : if2.PREADY;
        m_pslverr = (sel == 0) ? if0.PSLVERR : (sel == 1) ? if1.PSLVERR : if2.PSLVERR;
        m_prdata  = (sel == 0) ? if0.PRDATA  : (sel == 1) ? if1.PRDATA  : if2.PRDATA;
    end

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        int         s;
        bit         w;
        logic [6:0] a;
        logic [7:0] d;
        logic [7:0] exp_rd;
        logic       exp_err;
        int         exp_waits;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Setup phase on one negedge, access phase from the next; returns at the
    // negedge where PREADY is seen, leaving PSEL/PENABLE high through the
    // completion edge.
    task automatic xfer(input int s, input bit w, input logic [6:0] a, input logic [7:0] d,
                        output int waits, output logic [7:0] rd, output logic er, output bit ok);
        @(negedge PCLK);
        sel = s; psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        @(negedge PCLK);
        penable = 1'b1;
        waits = 0; rd = 8'h00; er = 1'b0; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m_pready) begin
                ok = 1'b1; rd = m_prdata; er = m_pslverr;
                break;
            end
            waits++;
            @(negedge PCLK);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL timeout: PREADY never rose, required within 20 cycles");
        end
    endtask

    task automatic idle();
        @(negedge PCLK);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic run(input string name, input int s, input bit w, input logic [6:0] a,
                       input logic [7:0] d, input logic [7:0] exp_rd, input logic exp_err, input int exp_waits);
        int waits; logic [7:0] rd; logic er; bit ok;
        xfer(s, w, a, d, waits, rd, er, ok);
        if (ok) begin
            check({name, " waits"}, waits, exp_waits);
            check({name, " prdata"}, {24'd0, rd}, {24'd0, exp_rd});
            check({name, " pslverr"}, {31'd0, er}, {31'd0, exp_err});
        end
    endtask

    initial begin
        logic prot;
        sel = 0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
`ifdef APB_SLAVE_WPROT_EN
        prot = 1'b1;
`else
        prot = 1'b0;
`endif
        //            s  w  addr   wdata  exp_rd exp_err waits
        vecs[0]  = '{0, 1, 7'h12, 8'hA5, 8'h00, 1'b0, 0};
        vecs[1]  = '{0, 0, 7'h12, 8'h00, 8'hA5, 1'b0, 0};
        vecs[2]  = '{2, 0, 7'h05, 8'h00, 8'h00, 1'b0, 3};
        vecs[3]  = '{1, 1, 7'h25, 8'h77, 8'h00, 1'b1, 2};
        vecs[4]  = '{1, 0, 7'h25, 8'h00, 8'h00, 1'b1, 2};
        vecs[5]  = '{1, 0, 7'h05, 8'h00, 8'h00, 1'b0, 2};
        vecs[6]  = '{0, 1, 7'h03, 8'h3C, 8'h00, prot, 0};
        vecs[7]  = '{0, 0, 7'h03, 8'h00, prot ? 8'h00 : 8'h3C, 1'b0, 0};
        vecs[8]  = '{0, 1, 7'h08, 8'h3C, 8'h00, 1'b0, 0};
        vecs[9]  = '{0, 0, 7'h48, 8'h00, 8'h3C, 1'b0, 0};
        vecs[10] = '{1, 0, 7'h20, 8'h00, 8'h00, 1'b1, 2};
        vecs[11] = '{1, 1, 7'h1F, 8'h5A, 8'h00, 1'b0, 2};
        vecs[12] = '{1, 0, 7'h1F, 8'h00, 8'h5A, 1'b0, 2};
        vecs[13] = '{0, 0, 7'h3F, 8'h00, 8'h00, 1'b0, 0};

        PRESET = 1'b0;
        repeat (3) @(negedge PCLK);
        check("reset pready0",  {31'd0, if0.PREADY},  32'd0);
        check("reset pslverr0", {31'd0, if0.PSLVERR}, 32'd0);
        check("reset prdata0",  {24'd0, if0.PRDATA},  32'd0);
        check("reset pready1",  {31'd0, if1.PREADY},  32'd0);
        check("reset pready2",  {31'd0, if2.PREADY},  32'd0);
        PRESET = 1'b1;
        @(negedge PCLK);

        // Access phase without setup is ignored
        penable = 1'b1; psel = 1'b1; sel = 0;
        repeat (2) @(negedge PCLK);
        check("no-setup pready", {31'd0, if0.PREADY}, 32'd0);
        idle();

        for (int i = 0; i < 14; i++) begin
            run($sformatf("vec%0d", i), vecs[i].s, vecs[i].w, vecs[i].a, vecs[i].d,
                vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_waits);
            idle();
        end

        // Back-to-back transfers with no idle cycles between them
        run("b2b w01", 0, 1, 7'h01, 8'h11, 8'h00, 1'b0, 0);
        run("b2b w02", 0, 1, 7'h02, 8'h22, 8'h00, 1'b0, 0);
        run("b2b r01", 0, 0, 7'h01, 8'h00, 8'h11, 1'b0, 0);
        run("b2b r02", 0, 0, 7'h02, 8'h00, 8'h22, 1'b0, 0);
        idle();

        // Abort: PSEL dropped after the first access cycle of a 2-wait write
        @(negedge PCLK);
        sel = 1; psel = 1; penable = 0; pwrite = 1; paddr = 7'h10; pwdata = 8'hFF;
        @(negedge PCLK);
        penable = 1;
        check("abort pready acc1", {31'd0, if1.PREADY}, 32'd0);
        @(negedge PCLK);
        psel = 0; penable = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            check("abort pready after", {31'd0, if1.PREADY}, 32'd0);
        end
        run("abort readback", 1, 0, 7'h10, 8'h00, 8'h00, 1'b0, 2);
        idle();

        // Reset pulsed in the middle of a 2-wait write
        run("pre-reset w11", 1, 1, 7'h11, 8'h66, 8'h00, 1'b0, 2);
        idle();
        @(negedge PCLK);
        sel = 1; psel = 1; penable = 0; pwrite = 1; paddr = 7'h10; pwdata = 8'hFF;
        @(negedge PCLK);
        penable = 1;
        @(negedge PCLK);
        PRESET = 1'b0;
        #1;
        check("reset mid pready", {31'd0, if1.PREADY}, 32'd0);
        @(negedge PCLK);
        psel = 0; penable = 0;
        PRESET = 1'b1;
        @(negedge PCLK);
        check("reset after pready", {31'd0, if1.PREADY}, 32'd0);
        run("reset readback 10", 1, 0, 7'h10, 8'h00, 8'h00, 1'b0, 2);
        run("reset cleared 11", 1, 0, 7'h11, 8'h00, 8'h00, 1'b0, 2);
        idle();

        repeat (2) @(negedge PCLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB completer holding a small byte-wide register file. It responds to transfers from the APB master on the shared PCLK bus. It decodes its own PSEL, inserts a programmable number of wait states, and returns PRDATA/PREADY/PSLVERR. Two instances sit behind the master's two select lines, split by PADDR[6].

## Interface
- DEPTH, 64: number of 8-bit locations; legal range 1..64; indexed by PADDR[5:0].
- WAIT_CYCLES, 0: wait states inserted per transfer; legal range 0..15.
- WPROT_LIMIT, 8: locations 0..WPROT_LIMIT-1 are write-protected; only used when APB_SLAVE_WPROT_EN is defined.
- PCLK  in  1  bus clock; all logic on rising edge.
- PRESET  in  1  reset, asynchronous assert, active-low.
- PSEL  in  1  select for this completer.
- PENABLE  in  1  access-phase strobe.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  7  address; bit 6 ignored; bits 5:0 index storage.
- PWDATA  in  8  write data.
- PRDATA  out  8  read data.
- PREADY  out  1  transfer completes this cycle.
- PSLVERR  out  1  transfer error; valid only while PREADY=1.

## Operation
- The FSM has two states, IDLE and ACCESS, plus a 4-bit wait counter cnt.
- Reset (PRESET=0, async) sets state=IDLE, cnt=0, all storage=0x00, and all latched transfer fields to 0.
- Reset values: PREADY=0, PSLVERR=0, PRDATA=0x00.
- **IDLE → ACCESS:**
  - Occurs on the edge where PSEL=1 and PENABLE=0 (setup phase).
  - On the same edge, latch PWRITE, PADDR[5:0], PWDATA, rdata_q=mem[PADDR[5:0]], and err_q.
  - Load cnt=WAIT_CYCLES.
- **Error condition err_q:**
  - PADDR[5:0] ≥ DEPTH.
  - With the macro only: a write with PADDR[5:0] < WPROT_LIMIT.
- **In ACCESS:**
  - PREADY = (cnt==0).
  - If cnt≠0 and PENABLE=1, cnt decrements each edge.
- **Completion edge:** ACCESS, PREADY=1, PSEL=1, PENABLE=1.
  - If write and !err_q: mem[addr] ← wdata.
  - Next state is IDLE.
- **Outputs:**
  - PSLVERR = PREADY & err_q.
  - PRDATA = rdata_q when PREADY & !write & !err_q; otherwise 0x00.
- An erroring write leaves storage unchanged. An erroring read returns 0x00.
- **Abort:** PSEL=0 while in ACCESS forces IDLE on the next edge. No write is performed and no response is given.
- PENABLE=1 with PSEL=1 while in IDLE (access with no setup) is ignored. The FSM stays in IDLE and PREADY stays 0.
- Reset mid-transfer returns to IDLE immediately (async) and drops any pending write.

## Timing
- WAIT_CYCLES=0:
  - Setup at cycle T; access at T+1 with PREADY=1.
  - A write is visible to a read issued from T+2 onward.
- WAIT_CYCLES=N: PREADY=0 for cycles T+1..T+N, and PREADY=1 at T+N+1.
- Back-to-back: after the completion edge, the completer is in IDLE. A new setup phase in the following cycle is accepted, so there are no dead cycles beyond the APB setup phase.
- Read data is the value at the setup edge. A write completing at that same edge is not reflected, because setup and completion edges never coincide for a single completer.
- PRDATA/PREADY/PSLVERR are derived only from registers and have no combinational path from bus inputs.

## Configuration
- APB_SLAVE_WPROT_EN:
  - Defined: writes to addresses 0..WPROT_LIMIT-1 complete with PSLVERR=1 and leave storage unchanged. Reads of those addresses are normal.
  - Undefined: no write protection. WPROT_LIMIT is unused, and every in-range address is read/write.

## Test plan
- Reset, then write 0xA5 to address 0x12 and read back 0x12, with WAIT_CYCLES=0 → PREADY=1 in each access cycle, PRDATA=0xA5, PSLVERR=0.
- WAIT_CYCLES=3: read address 0x05 after reset → PREADY low for 3 access cycles, then high with PRDATA=0x00.
- DEPTH=32: write 0x77 to address 0x25, then read 0x25 → both complete with PSLVERR=1; read PRDATA=0x00; no location changes.
- With the macro defined: write 0x3C to address 0x03 → PSLVERR=1, and a later read returns 0x00. Write 0x3C to address 0x08 → PSLVERR=0, and a read returns 0x3C.
- WAIT_CYCLES=2:
  - Drop PSEL after the first access cycle of a write of 0xFF to 0x10 → FSM returns to IDLE, PREADY never asserts, and a later read of 0x10 returns 0x00.
  - Repeat with PRESET pulsed low mid-access → same result.
- Back-to-back writes to 0x01 (0x11) and 0x02 (0x22), then reads, with no idle cycles between transfers → each completes in 2 cycles, and reads return 0x11 and 0x22.
